gpu_ctrl_regs: RTL and testbench

GPU_CTRL_REGS -- requirements
Module: gpu_ctrl_regs

---
 rtl/gpu_ctrl_regs.sv | 156 +++++++++++++++
 tb/tb_gpu_ctrl_regs.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_ctrl_regs.sv
// GPU control register block on an OBI slave port.
// Register map (32-bit words):
//   0 CTRL   : bit0 START (write-only pulse), bit1 IRQ_EN
//   1 STATUS : bit0 BUSY (live), bit1 DONE (sticky, write-1-to-clear)
//   2 CYCLES : busy-cycle counter, saturating, cleared by START
//   3..N-1   : general configuration words, byte-writable, exported on cfg_o
// Every granted request gets a response exactly one cycle later.
// A write response carries rdata_o = 0.

module gpu_ctrl_regs #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    // OBI slave port
    input  logic                         req_i,
    output logic                         gnt_o,
    input  logic                         we_i,
    input  logic [3:0]                   be_i,
    input  logic [31:0]                  addr_i,
    input  logic [31:0]                  wdata_i,
    output logic                         rvalid_o,
    output logic [31:0]                  rdata_o,
    output logic                         err_o,
    // GPU side
    input  logic                         gpu_busy_i,
    input  logic                         gpu_done_i,
    output logic                         gpu_start_o,
    output logic                         irq_o,
    output logic [32*(NUM_REGS-3)-1:0]   cfg_o
);

    localparam int unsigned NUM_CFG = NUM_REGS - 3;

    // Decoded request
    logic [IDX_W-1:0] req_idx;
    logic             req_oor;
    logic             wr_ok;
    logic             rd_ok;
    logic             ctrl_wr;
    logic             status_w1c;
    logic             start_issue;
    logic [31:0]      rd_val;

    // State
    logic             irq_en_q, irq_en_d;
    logic             done_q, done_d;
    logic             start_q, start_d;
    logic [31:0]      cycles_q, cycles_d;
    logic [31:0]      cfg_q [NUM_CFG];
    logic [31:0]      cfg_d [NUM_CFG];
    logic             rvalid_q, rvalid_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;

    // Grant is immediate, but nothing is accepted while reset is held.
    assign gnt_o = req_i & rst_ni;

    assign req_idx     = addr_i[IDX_W+1:2];
    assign req_oor     = (addr_i[31:IDX_W+2] != '0) || (32'(req_idx) >= NUM_REGS);
    assign wr_ok       = gnt_o & ~req_oor & we_i;
    assign rd_ok       = gnt_o & ~req_oor & ~we_i;
    assign ctrl_wr     = wr_ok & (req_idx == IDX_W'(0)) & be_i[0];
    assign status_w1c  = wr_ok & (req_idx == IDX_W'(1)) & be_i[0] & wdata_i[1];
    assign start_issue = ctrl_wr & wdata_i[0] & ~gpu_busy_i;

    // Read mux over the current (pre-write) register contents.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
        rd_val = '0;
        if (req_idx == IDX_W'(0)) begin
            rd_val = {30'd0, irq_en_q, 1'b0};
        end else if (req_idx == IDX_W'(1)) begin
            rd_val = {30'd0, done_q, gpu_busy_i};
        end else if (req_idx == IDX_W'(2)) begin
            rd_val = cycles_q;
        end else begin
            for (int i = 0; i < int'(NUM_CFG); i++) begin
                if (req_idx == IDX_W'(i + 3)) begin
                    rd_val = cfg_q[i];
                end
            end
        end
    end

    // Next-state for control/status/counter/config words and the response stage.
    always_comb begin
        irq_en_d = irq_en_q;
        if (ctrl_wr) begin
            irq_en_d = wdata_i[1];
        end

        // A completion in the same cycle as a clear keeps DONE set.
        done_d  = gpu_done_i | (done_q & ~(status_w1c | start_issue));
        start_d = start_issue;

        cycles_d = cycles_q;
        if (start_issue) begin
            cycles_d = '0;
        end else if (gpu_busy_i && (cycles_q != '1)) begin
            cycles_d = cycles_q + 32'd1;
        end

        cfg_d = cfg_q;
        for (int i = 0; i < int'(NUM_CFG); i++) begin
            if (wr_ok && (req_idx == IDX_W'(i + 3))) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) begin
                        cfg_d[i][8*b +: 8] = wdata_i[8*b +: 8];
                    end
                end
            end
        end

        rvalid_d = gnt_o;
        err_d    = gnt_o & req_oor;
        rdata_d  = rd_ok ? rd_val : 32'd0;
    end

    // All state, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= 1'b0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            cycles_q <= '0;
            // NOTE: the config array is a handful of flops exported on cfg_o, not a RAM, so it is reset.
            cfg_q    <= '{default: '0};
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            irq_en_q <= irq_en_d;
            done_q   <= done_d;
            start_q  <= start_d;
            cycles_q <= cycles_d;
            cfg_q    <= cfg_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign rvalid_o    = rvalid_q;
    assign err_o       = err_q;
    assign rdata_o     = rdata_q;
    assign gpu_start_o = start_q;
    assign irq_o       = irq_en_q & done_q;

    for (genvar g = 0; g < int'(NUM_CFG); g++) begin : g_cfg_out
        assign cfg_o[32*g +: 32] = cfg_q[g];
    end

endmodule

// File: tb/tb_gpu_ctrl_regs.sv
// Self-checking bench for gpu_ctrl_regs: directed scenarios followed by
// randomized traffic, all compared against a behavioural register model.

module tb_gpu_ctrl_regs;

    localparam int NUM_REGS = 8;
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int CFG_W    = 32 * (NUM_REGS - 3);

    logic              clk_i;
    logic              rst_ni;
    logic              req_i;
    logic              gnt_o;
    logic              we_i;
    logic [3:0]        be_i;
    logic [31:0]       addr_i;
    logic [31:0]       wdata_i;
    logic              rvalid_o;
    logic [31:0]       rdata_o;
    logic              err_o;
    logic              gpu_busy_i;
    logic              gpu_done_i;
    logic              gpu_start_o;
    logic              irq_o;
    logic [CFG_W-1:0]  cfg_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_irq_en;
    bit          m_done;
    longint      m_cycles;
    logic [31:0] m_cfg [NUM_REGS];

    gpu_ctrl_regs #(.NUM_REGS(NUM_REGS)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .we_i        (we_i),
        .be_i        (be_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .gpu_busy_i  (gpu_busy_i),
        .gpu_done_i  (gpu_done_i),
        .gpu_start_o (gpu_start_o),
        .irq_o       (irq_o),
        .cfg_o       (cfg_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_irq_en = 1'b0;
        m_done   = 1'b0;
        m_cycles = 0;
        for (int i = 0; i < NUM_REGS; i++) m_cfg[i] = 32'd0;
    endtask

    function automatic logic [31:0] model_read(input int idx, input logic busy);
        case (idx)
            0:       return {30'd0, m_irq_en, 1'b0};
            1:       return {30'd0, m_done, busy};
            2:       return m_cycles[31:0];
            default: return m_cfg[idx];
        endcase
    endfunction

    function automatic logic [CFG_W-1:0] model_cfg();
        logic [CFG_W-1:0] v;
        v = '0;
        for (int i = 3; i < NUM_REGS; i++) v[32*(i-3) +: 32] = m_cfg[i];
        return v;
    endfunction

    // One bus cycle: drive inputs, check the combinational grant, clock, then
    // check the response and GPU-side outputs against the model.
    task automatic cycle(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic busy, input logic done);
        int          idx;
        bit          oor;
        bit          ok;
        bit          w1c;
        bit          exp_start;
        logic [31:0] exp_rdata;
        logic [31:0] mask;

        req_i = req; we_i = we; be_i = be; addr_i = addr; wdata_i = wdata;
        gpu_busy_i = busy; gpu_done_i = done;
        #1;
        check("gnt", gnt_o, req);

        idx       = int'((addr >> 2) % (32'd1 << IDX_W));
        oor       = ((addr >> (IDX_W + 2)) != 0) || (idx >= NUM_REGS);
        ok        = req && !oor;
        exp_rdata = (ok && !we) ? model_read(idx, busy) : 32'd0;
        exp_start = ok && we && idx == 0 && be[0] && wdata[0] && !busy;
        w1c       = ok && we && idx == 1 && be[0] && wdata[1];

        if (ok && we && idx == 0 && be[0]) m_irq_en = wdata[1];
        m_done = done || (m_done && !(w1c || exp_start));
        if (exp_start) m_cycles = 0;
        else if (busy && m_cycles < 64'hFFFF_FFFF) m_cycles = m_cycles + 1;
        if (ok && we && idx >= 3) begin
            mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
            m_cfg[idx] = (m_cfg[idx] & ~mask) | (wdata & mask);
        end

        @(posedge clk_i);
        #1;
        check("rvalid", rvalid_o, req);
        check("err", err_o, req && oor);
        check("rdata", rdata_o, exp_rdata);
        check("start", gpu_start_o, exp_start);
        check("irq", irq_o, m_irq_en && m_done);
        check("cfg", cfg_o, model_cfg());
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, gnt_o, 1'b0);
        check({tag, "_rvalid"}, rvalid_o, 1'b0);
        check({tag, "_err"}, err_o, 1'b0);
        check({tag, "_rdata"}, rdata_o, 32'd0);
        check({tag, "_start"}, gpu_start_o, 1'b0);
        check({tag, "_irq"}, irq_o, 1'b0);
        check({tag, "_cfg"}, cfg_o, '0);
    endtask

    initial begin
        int          sel;
        int          ridx;
        logic        r_req;
        logic        r_we;
        logic [3:0]  r_be;
        logic [31:0] r_addr;
        logic [31:0] r_wdata;
        logic        r_busy;
        logic        r_done;

        rst_ni = 1'b0;
        req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'd0; wdata_i = 32'd0;
        gpu_busy_i = 1'b0; gpu_done_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        rst_ni = 1'b1;
        req_i  = 1'b0;

        // START with GPU idle: one-cycle pulse, counter cleared, CTRL reads IRQ_EN only.
        cycle(1, 1, 4'hF, 32'h0, 32'h3, 0, 0);
        check("start_pulse", gpu_start_o, 1'b1);
        cycle(1, 0, 4'hF, 32'h0, 32'h0, 0, 0);
        check("start_one_cycle", gpu_start_o, 1'b0);
        check("ctrl_read", rdata_o, 32'h2);
        cycle(1, 0, 4'hF, 32'h8, 32'h0, 0, 0);
        check("cycles_cleared", rdata_o, 32'd0);

        // 10 busy cycles, then completion.
        repeat (10) cycle(0, 0, 4'h0, 32'h0, 32'h0, 1, 0);
        cycle(0, 0, 4'h0, 32'h0, 32'h0, 0, 1);
        check("irq_after_done", irq_o, 1'b1);
        cycle(1, 0, 4'hF, 32'h8, 32'h0, 0, 0);
        check("cycles_10", rdata_o, 32'd10);
        cycle(1, 0, 4'hF, 32'h4, 32'h0, 0, 0);
        check("status_done", rdata_o, 32'h2);

        // W1C collides with completion: set wins. Then W1C alone clears.
        cycle(1, 1, 4'hF, 32'h4, 32'h2, 0, 1);
        check("w1c_vs_done_irq", irq_o, 1'b1);
        cycle(1, 1, 4'hF, 32'h4, 32'h2, 0, 0);
        check("w1c_irq_low", irq_o, 1'b0);
        cycle(1, 0, 4'hF, 32'h4, 32'h0, 0, 0);
        check("status_cleared", rdata_o, 32'h0);

        // Back-to-back byte-masked write then read of reg3.
        cycle(1, 1, 4'b0101, 32'hC, 32'hA5A5_A5A5, 0, 0);
        cycle(1, 0, 4'hF, 32'hC, 32'h0, 0, 0);
        check("reg3_masked", rdata_o, 32'h00A5_00A5);
        check("cfg_reg3", cfg_o[31:0], 32'h00A5_00A5);

        // Out-of-range accesses: error response, no state change.
        cycle(1, 0, 4'hF, 32'(4 * NUM_REGS), 32'h0, 0, 0);
        check("oor_rd_err", err_o, 1'b1);
        check("oor_rd_data", rdata_o, 32'd0);
        cycle(1, 1, 4'hF, 32'(4 * NUM_REGS), 32'hFFFF_FFFF, 0, 0);
        check("oor_wr_err", err_o, 1'b1);
        cycle(1, 1, 4'hF, 32'h8000_000C, 32'hFFFF_FFFF, 0, 0);
        check("oor_upper_err", err_o, 1'b1);
        check("oor_cfg_kept", cfg_o[31:0], 32'h00A5_00A5);

        // START while busy: no pulse, IRQ_EN still written.
        cycle(1, 1, 4'hF, 32'h0, 32'h1, 1, 0);
        check("busy_no_start", gpu_start_o, 1'b0);
        cycle(1, 0, 4'hF, 32'h0, 32'h0, 1, 0);
        check("busy_irq_en_written", rdata_o, 32'h0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            r_req   = ($urandom_range(0, 3) != 0);
            r_we    = $urandom_range(0, 1);
            r_be    = 4'($urandom);
            sel     = $urandom_range(0, 9);
            ridx    = $urandom_range(0, NUM_REGS - 1);
            r_addr  = 32'(ridx * 4) | 32'($urandom_range(0, 3));
            if (sel == 8) r_addr = 32'(4 * NUM_REGS);
            if (sel == 9) r_addr = r_addr | (32'd1 << $urandom_range(IDX_W + 2, 31));
            r_wdata = $urandom;
            r_busy  = ($urandom_range(0, 3) != 0);
            r_done  = ($urandom_range(0, 7) == 0);
            cycle(r_req, r_we, r_be, r_addr, r_wdata, r_busy, r_done);
        end

        // Reset while a START pulse and a new request are in flight.
        cycle(1, 1, 4'hF, 32'h0, 32'h3, 0, 1);
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h8;
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk_i);
        #1;
        check_all_zero("mid_reset_held");
        model_reset();
        req_i  = 1'b0;
        rst_ni = 1'b1;
        repeat (3) cycle(0, 0, 4'h0, 32'h0, 32'h0, 0, 0);
        check("post_reset_rvalid", rvalid_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
